// File: rtl/asyn_fifo_pkg.sv
// Shared helpers for the asyn_fifo_prog dual-clock FIFO: gray/binary
// pointer conversion and depth calculation.
package asyn_fifo_pkg;

  // Widest pointer the conversion helpers handle; callers cast to their width.
  localparam int unsigned PTR_MAX = 32;

  function automatic int unsigned DEPTH(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
    logic [PTR_MAX-1:0] bin;
    bin = gray;
    for (int unsigned i = 1; i < PTR_MAX; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/asyn_fifo_sync.sv
// Multi-bit flop chain used to carry a gray-coded pointer into another
// clock domain. Only one bit changes per source update, so sampling the
// whole word is safe.
module asyn_fifo_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the incoming pointer through STAGES flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/asyn_fifo_prog.sv
// Dual-clock FIFO with programmable almost_full/almost_empty thresholds,
// per-domain fill counts and sticky overflow/underflow flags.
// Define ASYN_FIFO_FWFT_EN for first-word-fall-through reads; otherwise
// reads have one cycle of latency.
module asyn_fifo_prog
  import asyn_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int unsigned PW         = ADDR_WIDTH + 1;
  localparam int unsigned FIFO_DEPTH = DEPTH(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wr_bin, wr_gray, wr_bin_next, wr_gray_next;
  logic [PW-1:0] rd_gray_sync, rd_bin_sync, wr_count_next, full_match;
  logic          wr_inc;

  assign wr_inc        = wr_en & ~full;
  assign wr_bin_next   = wr_bin + PW'(wr_inc);
  assign wr_gray_next  = PW'(bin2gray(PTR_MAX'(wr_bin_next)));
  assign rd_bin_sync   = PW'(gray2bin(PTR_MAX'(rd_gray_sync)));
  assign wr_count_next = wr_bin_next - rd_bin_sync;
  // Gray value the write pointer reaches exactly one lap ahead of the read pointer.
  assign full_match    = rd_gray_sync ^ {2'b11, {(PW-2){1'b0}}};

  // Write pointer, flags and fill count.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin      <= '0;
      wr_gray     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_gray     <= wr_gray_next;
      full        <= (wr_gray_next == full_match);
      wr_count    <= wr_count_next;
      almost_full <= (wr_count_next >= af_thresh);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge wr_clk) begin
    if (wr_inc) begin
      mem[wr_bin[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // ---------------- pointer crossings ----------------
  logic [PW-1:0] rd_gray, wr_gray_sync;

  asyn_fifo_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rd2wr (
    .clk   (wr_clk),
    .rst_n (wr_rst_n),
    .d     (rd_gray),
    .q     (rd_gray_sync)
  );

  asyn_fifo_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wr2rd (
    .clk   (rd_clk),
    .rst_n (rd_rst_n),
    .d     (wr_gray),
    .q     (wr_gray_sync)
  );

  // ---------------- read domain ----------------
  logic [PW-1:0] rd_bin, rd_bin_next, rd_gray_next, wr_bin_sync, rd_count_next;
  logic          rd_inc;
  logic          ram_empty;

  assign rd_bin_next  = rd_bin + PW'(rd_inc);
  assign rd_gray_next = PW'(bin2gray(PTR_MAX'(rd_bin_next)));
  assign wr_bin_sync  = PW'(gray2bin(PTR_MAX'(wr_gray_sync)));

  // Read pointer and storage-empty flag.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin    <= '0;
      rd_gray   <= '0;
      ram_empty <= 1'b1;
    end else begin
      rd_bin    <= rd_bin_next;
      rd_gray   <= rd_gray_next;
      ram_empty <= (rd_gray_next == wr_gray_sync);
    end
  end

`ifdef ASYN_FIFO_FWFT_EN
  // A prefetch register sits in front of the array; the array is read
  // whenever the register is free or being consumed, so empty/rd_count
  // describe the register plus the array.
  logic pf_valid, pf_valid_next;

  assign rd_inc        = ~ram_empty & (~pf_valid | rd_en);
  assign pf_valid_next = rd_inc | (pf_valid & ~rd_en);
  assign rd_count_next = wr_bin_sync - rd_bin_next + PW'(pf_valid_next);
  assign empty         = ~pf_valid;
  assign rd_valid      = rd_en & pf_valid;

  // Prefetch register, read-side count and sticky underflow.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      pf_valid     <= 1'b0;
      rd_data      <= '0;
      rd_count     <= '0;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
    end else begin
      pf_valid     <= pf_valid_next;
      rd_count     <= rd_count_next;
      almost_empty <= (rd_count_next <= ae_thresh);
      if (rd_inc) begin
        rd_data <= mem[rd_bin[ADDR_WIDTH-1:0]];
      end
      if (rd_en && !pf_valid) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign rd_inc        = rd_en & ~ram_empty;
  assign rd_count_next = wr_bin_sync - rd_bin_next;
  assign empty         = ram_empty;

  // Registered read data, valid strobe, read-side count and sticky underflow.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_count     <= '0;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
    end else begin
      rd_valid     <= rd_inc;
      rd_count     <= rd_count_next;
      almost_empty <= (rd_count_next <= ae_thresh);
      if (rd_inc) begin
        rd_data <= mem[rd_bin[ADDR_WIDTH-1:0]];
      end
      if (rd_en && ram_empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_asyn_fifo_prog.sv
// Bench for asyn_fifo_prog: queue-based reference model with per-cycle
// compare processes in each clock domain, plus directed scenarios.
module tb_asyn_fifo_prog;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef ASYN_FIFO_FWFT_EN
  localparam int SLACK = 1;
`else
  localparam int SLACK = 0;
`endif

  logic          wr_clk, rd_clk, wr_rst_n, rd_rst_n;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW:0]   af_thresh, ae_thresh, wr_count, rd_count;
  logic          full, almost_full, overflow;
  logic          rd_valid, empty, almost_empty, underflow;

  asyn_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .af_thresh    (af_thresh),
    .full         (full),
    .almost_full  (almost_full),
    .wr_count     (wr_count),
    .overflow     (overflow),
    .rd_en        (rd_en),
    .ae_thresh    (ae_thresh),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .underflow    (underflow)
  );

  // Clocks: wr period 20, rd period 60, offset so edges never coincide.
  initial begin
    wr_clk = 1'b0;
    forever #10 wr_clk = ~wr_clk;
  end
  initial begin
    rd_clk = 1'b0;
    #7;
    forever begin
      rd_clk = 1'b1; #30;
      rd_clk = 1'b0; #30;
    end
  end

  int total, bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO content as a queue of words in write order.
  logic [DW-1:0] q[$];
  int            pops;
  bit            exp_ovf, exp_unf, pend;
  logic [DW-1:0] exp_d, last_d;
  logic [AW:0]   af_seen, ae_seen;

  // Write-side model: accepted writes join the queue, blocked ones set overflow.
  always @(posedge wr_clk) begin
    af_seen = af_thresh;
    if (wr_rst_n && rd_rst_n && wr_en) begin
      if (full) exp_ovf = 1'b1;
      else q.push_back(wr_data);
    end
  end

  // Read-side model: pops take the oldest queued word.
  always @(posedge rd_clk) begin
    ae_seen = ae_thresh;
    if (wr_rst_n && rd_rst_n) begin
`ifndef ASYN_FIFO_FWFT_EN
      pend = 1'b0;
`endif
      if (rd_en && !empty) begin
        check("pop_has_data", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp_d = q.pop_front();
          pops++;
`ifndef ASYN_FIFO_FWFT_EN
          pend   = 1'b1;
          last_d = exp_d;
`endif
        end
      end else if (rd_en) begin
        exp_unf = 1'b1;
      end
    end
  end

  // Write-side compare.
  always @(negedge wr_clk) begin
    if (wr_rst_n && rd_rst_n) begin
      check("overflow", overflow, exp_ovf);
      check("full_vs_wr_count", full, wr_count == DEPTH);
      check("af_vs_wr_count", almost_full, wr_count >= af_seen);
      check("wr_count_ge_occ", int'(wr_count) + SLACK >= q.size(), 1);
      check("wr_count_le_depth", wr_count <= DEPTH, 1);
    end
  end

  // Read-side compare.
  always @(negedge rd_clk) begin
    if (wr_rst_n && rd_rst_n) begin
      check("underflow", underflow, exp_unf);
      check("ae_vs_rd_count", almost_empty, rd_count <= ae_seen);
      check("rd_count_le_occ", int'(rd_count) <= q.size(), 1);
`ifdef ASYN_FIFO_FWFT_EN
      check("rd_valid", rd_valid, rd_en && !empty);
      if (!empty) begin
        check("head_present", q.size() > 0, 1);
        if (q.size() > 0) check("rd_data_head", rd_data, q[0]);
      end
`else
      check("rd_valid", rd_valid, pend);
      if (pend) check("rd_data", rd_data, exp_d);
      else      check("rd_data_hold", rd_data, last_d);
      check("empty_vs_rd_count", empty, rd_count == 0);
`endif
    end
  end

  task automatic settle;
    repeat (8) @(posedge rd_clk);
    #1;
  endtask

  task automatic do_read(output logic [DW-1:0] d, output logic v);
    @(posedge rd_clk); #1;
    rd_en = 1'b1;
`ifdef ASYN_FIFO_FWFT_EN
    v = !empty;
    d = rd_data;
`endif
    @(posedge rd_clk); #1;
    rd_en = 1'b0;
`ifndef ASYN_FIFO_FWFT_EN
    v = rd_valid;
    d = rd_data;
`endif
  endtask

  task automatic write_words(input int n, input int base);
    @(posedge wr_clk); #1;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(base + i);
      @(posedge wr_clk); #1;
    end
    wr_en = 1'b0;
  endtask

  // Watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic          v;
    int            n1, sent, target, c;
    bit            to_w, to_r;

    total = 0; bad = 0; pops = 0;
    exp_ovf = 0; exp_unf = 0; pend = 0; last_d = '0; exp_d = '0;
    wr_rst_n = 0; rd_rst_n = 0;
    wr_en = 0; rd_en = 0; wr_data = '0;
    af_thresh = 5'd12; ae_thresh = 5'd3;
    af_seen = 5'd12; ae_seen = 5'd3;
    repeat (3) @(posedge rd_clk);
    #1;
    wr_rst_n = 1; rd_rst_n = 1;
    #1;
    check("rst_empty", empty, 1);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);

    // 1: fill to full, then one blocked write.
`ifndef ASYN_FIFO_FWFT_EN
    @(posedge wr_clk); #1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(i);
      @(posedge wr_clk); #1;
      check("t1_wr_count", wr_count, i + 1);
      check("t1_almost_full", almost_full, (i + 1) >= 12);
      check("t1_full", full, i == 15);
    end
    n1 = 16;
    wr_data = 16'd16;
    @(posedge wr_clk); #1;
    wr_en = 1'b0;
    check("t1_overflow", overflow, 1);
    check("t1_count_held", wr_count, 16);
    af_thresh = 5'd17;
    repeat (2) @(posedge wr_clk); #1;
    check("t1_af_above_depth", almost_full, 0);
    af_thresh = 5'd12;
    repeat (2) @(posedge wr_clk); #1;
    check("t1_af_restored", almost_full, 1);
`else
    @(posedge wr_clk); #1;
    n1 = 0;
    while (!full && n1 < 24) begin
      wr_en = 1'b1;
      wr_data = DW'(n1);
      @(posedge wr_clk); #1;
      n1++;
    end
    check("t1_fwft_full", full, 1);
    check("t1_fwft_capacity", n1 >= 16 && n1 <= 17, 1);
    wr_data = DW'(n1);
    @(posedge wr_clk); #1;
    wr_en = 1'b0;
    check("t1_overflow", overflow, 1);
`endif

    // 2: drain in order, then read once more while empty.
    settle();
    for (int i = 0; i < n1; i++) begin
      do_read(d, v);
      check("t2_valid", v, 1);
      check("t2_data", d, i);
    end
    check("t2_empty", empty, 1);
    do_read(d, v);
    check("t2_extra_valid", v, 0);
    check("t2_underflow", underflow, 1);

    // 3: concurrent random traffic, 200 words.
    settle();
    sent = 0; to_w = 0; to_r = 0;
    target = pops + 200;
    fork
      begin
        @(posedge wr_clk); #1;
        for (int k = 0; k < 20000 && sent < 200; k++) begin
          if (!full && $urandom_range(0, 2) == 0) begin
            wr_en = 1'b1;
            wr_data = DW'($urandom);
            sent++;
          end else begin
            wr_en = 1'b0;
          end
          @(posedge wr_clk); #1;
        end
        wr_en = 1'b0;
        to_w = (sent < 200);
      end
      begin
        @(posedge rd_clk); #1;
        for (int k = 0; k < 8000 && pops < target; k++) begin
          rd_en = !empty && ($urandom_range(0, 1) == 1);
          @(posedge rd_clk); #1;
        end
        rd_en = 1'b0;
        to_r = (pops < target);
      end
    join
    check("t3_writer_timeout", to_w, 0);
    check("t3_reader_timeout", to_r, 0);
    check("t3_model_drained", q.size(), 0);
    settle();
    check("t3_empty", empty, 1);
    check("t3_rd_count", rd_count, 0);
    check("t3_wr_count", wr_count, 0);

    // 4: almost_empty around ae_thresh=3 with 5 words.
    write_words(5, 100);
    c = 0;
    while (almost_empty && c < 30) begin
      @(posedge rd_clk); #1;
      c++;
    end
    check("t4_ae_deasserted", almost_empty, 0);
    check("t4_count_at_deassert", rd_count >= 4, 1);
    settle();
    check("t4_rd_count5", rd_count, 5);
    do_read(d, v);
    check("t4_rd_count4", rd_count, 4);
    check("t4_ae_after_pop1", almost_empty, 0);
    do_read(d, v);
    check("t4_rd_count3", rd_count, 3);
    check("t4_ae_after_pop2", almost_empty, 1);
    for (int i = 0; i < 3; i++) begin
      do_read(d, v);
      check("t4_drain_data", d, 102 + i);
    end
    settle();

    // 5: reset both domains while holding 8 words.
    write_words(8, 200);
    settle();
    check("t5_holding", rd_count, 8);
    wr_rst_n = 0; rd_rst_n = 0;
    q.delete();
    exp_ovf = 0; exp_unf = 0; pend = 0; last_d = '0;
    repeat (3) @(posedge rd_clk);
    #1;
    wr_rst_n = 1; rd_rst_n = 1;
    #1;
    check("t5_empty", empty, 1);
    check("t5_full", full, 0);
    check("t5_wr_count", wr_count, 0);
    check("t5_rd_count", rd_count, 0);
    check("t5_overflow", overflow, 0);
    check("t5_underflow", underflow, 0);
    write_words(1, 16'h1234);
    settle();
    do_read(d, v);
    check("t5_new_valid", v, 1);
    check("t5_new_data", d, 16'h1234);

`ifdef ASYN_FIFO_FWFT_EN
    // 6: first word falls through without a read request.
    settle();
    write_words(1, 16'hA5A5);
    c = 0;
    while (empty && c < 30) begin
      @(posedge rd_clk); #1;
      c++;
    end
    check("t6_not_empty", empty, 0);
    check("t6_head", rd_data, 16'hA5A5);
    check("t6_no_valid_idle", rd_valid, 0);
    do_read(d, v);
    check("t6_valid", v, 1);
    check("t6_data", d, 16'hA5A5);
    check("t6_empty_after", empty, 1);
`endif

    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
